// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent programmable clock-enable dividers, each with a 50% square wave and a tick strobe.
// Define CLKDIV_DEFERRED_LOAD_EN to hold divisor writes in a shadow register until the channel wraps.
module multi_channel_clock_divider #(
  parameter int                      NUM_CH   = 2,
  parameter int                      CNT_W    = 25,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {25'd25000000, 25'd25000}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_clr_i,
  input  logic              div_wr_i,
  input  logic [2:0]        div_ch_i,
  input  logic [CNT_W-1:0]  div_data_i,
  output logic              div_err_o,
  output logic [NUM_CH-1:0] clk_out_o,
  output logic [NUM_CH-1:0] tick_o
);

  localparam logic [3:0]       NUM_CH_W = 4'(NUM_CH);
  localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2);

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  clampData, cntInc, halfDiv;
  logic              chInRange, wrValid, wrHit, wrapHit;

`ifdef CLKDIV_DEFERRED_LOAD_EN
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  loadDiv;
`endif

  always_comb begin
    clampData = (div_data_i < MIN_DIV) ? MIN_DIV : div_data_i;
    chInRange = ({1'b0, div_ch_i} < NUM_CH_W);
    wrValid   = div_wr_i && chInRange;
    err_d     = div_wr_i && !chInRange;
    wrHit     = 1'b0;
    wrapHit   = 1'b0;
    cntInc    = '0;
    halfDiv   = '0;
    clk_d     = clk_q;
    tick_d    = '0;
`ifdef CLKDIV_DEFERRED_LOAD_EN
    pend_d    = pend_q;
    loadDiv   = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      div_d[i] = div_q[i];
      wrHit    = wrValid && (div_ch_i == 3'(i));
      wrapHit  = en_i[i] && (cnt_q[i] == div_q[i] - CNT_W'(1));
      cntInc   = cnt_q[i] + CNT_W'(1);
      // ceil(div/2) without needing an extra carry bit
      halfDiv  = div_q[i] - (div_q[i] >> 1);
`ifdef CLKDIV_DEFERRED_LOAD_EN
      shadow_d[i] = shadow_q[i];
      // A write landing on a restart edge is taken directly instead of being parked
      loadDiv = wrHit ? clampData : (pend_q[i] ? shadow_q[i] : div_q[i]);
      if (sync_clr_i || wrapHit) begin
        cnt_d[i]  = '0;
        clk_d[i]  = 1'b0;
        tick_d[i] = !sync_clr_i;
        div_d[i]  = loadDiv;
        pend_d[i] = 1'b0;
      end else begin
        if (wrHit) begin
          shadow_d[i] = clampData;
          pend_d[i]   = 1'b1;
        end
        if (en_i[i]) begin
          cnt_d[i] = cntInc;
          clk_d[i] = (cntInc >= halfDiv);
        end
      end
`else
      if (sync_clr_i) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        if (wrHit) div_d[i] = clampData;
      end else if (wrHit) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        div_d[i] = clampData;
      end else if (wrapHit) begin
        cnt_d[i]  = '0;
        clk_d[i]  = 1'b0;
        tick_d[i] = 1'b1;
      end else if (en_i[i]) begin
        cnt_d[i] = cntInc;
        clk_d[i] = (cntInc >= halfDiv);
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
`ifdef CLKDIV_DEFERRED_LOAD_EN
        shadow_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
`endif
      end
      clk_q  <= '0;
      tick_q <= '0;
      err_q  <= 1'b0;
`ifdef CLKDIV_DEFERRED_LOAD_EN
      pend_q <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
`ifdef CLKDIV_DEFERRED_LOAD_EN
        shadow_q[i] <= shadow_d[i];
`endif
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
      err_q  <= err_d;
`ifdef CLKDIV_DEFERRED_LOAD_EN
      pend_q <= pend_d;
`endif
    end
  end

  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;
  assign div_err_o = err_q;

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Self-checking bench for multi_channel_clock_divider: fixed vector table, directed corner sequences,
// and randomized traffic compared against an elapsed-cycle reference model.
module tb_multi_channel_clock_divider;

  localparam int INIT0 = 25000;
  localparam int INIT1 = 25000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  en = '0;
  logic        syncClr = 1'b0;
  logic        divWr = 1'b0;
  logic [2:0]  divCh = '0;
  logic [24:0] divData = '0;
  logic        divErr;
  logic [1:0]  clkOut;
  logic [1:0]  tick;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed enabled cycles inside the current period, plus the active divisor
  int         elapsed [2];
  int         mdiv [2];
  int         shadow [2];
  bit         pend [2];
  logic [1:0] mclk;
  logic [1:0] mtick;
  logic       merr;

  typedef struct {
    logic        r;
    logic [1:0]  en;
    logic        s;
    logic        w;
    logic [2:0]  ch;
    logic [24:0] d;
    logic [1:0]  eClk;
    logic [1:0]  eTick;
    logic        eErr;
  } vec_t;

  vec_t tbl [$];

  multi_channel_clock_divider #(
    .NUM_CH(2),
    .CNT_W(25),
    .DIV_INIT({25'd25000000, 25'd25000})
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .en_i(en),
    .sync_clr_i(syncClr),
    .div_wr_i(divWr),
    .div_ch_i(divCh),
    .div_data_i(divData),
    .div_err_o(divErr),
    .clk_out_o(clkOut),
    .tick_o(tick)
  );

  always #20 clk = ~clk;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic r, input logic [1:0] e, input logic s, input logic w,
                              input logic [2:0] c, input logic [24:0] d,
                              input logic [1:0] eClk, input logic [1:0] eTick, input logic eErr);
    vec_t v;
    v.r = r; v.en = e; v.s = s; v.w = w; v.ch = c; v.d = d;
    v.eClk = eClk; v.eTick = eTick; v.eErr = eErr;
    return v;
  endfunction

  task automatic modelStep(input logic r, input logic [1:0] e, input logic s, input logic w,
                           input logic [2:0] c, input logic [24:0] d);
    int  nd;
    bit  hit;
    bit  restarted;
    if (r) begin
      elapsed = '{0, 0};
      mdiv    = '{INIT0, INIT1};
      pend    = '{0, 0};
      mclk    = '0;
      mtick   = '0;
      merr    = 1'b0;
      return;
    end
    merr = w && (c >= 3'd2);
    nd   = (int'(d) < 2) ? 2 : int'(d);
    for (int ch = 0; ch < 2; ch++) begin
      hit       = w && (int'(c) == ch);
      restarted = 0;
      mtick[ch] = 1'b0;
      if (s) begin
        elapsed[ch] = 0;
        mclk[ch]    = 1'b0;
        restarted   = 1;
        if (hit) mdiv[ch] = nd;
        else if (pend[ch]) mdiv[ch] = shadow[ch];
        pend[ch] = 0;
      end
`ifndef CLKDIV_DEFERRED_LOAD_EN
      else if (hit) begin
        mdiv[ch]    = nd;
        elapsed[ch] = 0;
        mclk[ch]    = 1'b0;
        restarted   = 1;
      end
`endif
      else if (e[ch]) begin
        if (elapsed[ch] + 1 == mdiv[ch]) begin
          elapsed[ch] = 0;
          mtick[ch]   = 1'b1;
          mclk[ch]    = 1'b0;
          restarted   = 1;
`ifdef CLKDIV_DEFERRED_LOAD_EN
          if (hit) mdiv[ch] = nd;
          else if (pend[ch]) mdiv[ch] = shadow[ch];
          pend[ch] = 0;
`endif
        end else begin
          elapsed[ch] = elapsed[ch] + 1;
          mclk[ch]    = (elapsed[ch] >= (mdiv[ch] + 1) / 2);
        end
      end
`ifdef CLKDIV_DEFERRED_LOAD_EN
      if (hit && !restarted) begin
        shadow[ch] = nd;
        pend[ch]   = 1;
      end
`endif
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] e, input logic s, input logic w,
                               input logic [2:0] c, input logic [24:0] d);
    rst = r; en = e; syncClr = s; divWr = w; divCh = c; divData = d;
    @(posedge clk);
    #1;
    modelStep(r, e, s, w, c, d);
  endtask

  task automatic checkOutput(input string name, input logic [1:0] expClk,
                             input logic [1:0] expTick, input logic expErr);
    checks++;
    if (clkOut !== expClk) begin
      errors++;
      $display("[TB] FAIL %s clk_out: got %b expected %b at %0t", name, clkOut, expClk, $time);
    end
    checks++;
    if (tick !== expTick) begin
      errors++;
      $display("[TB] FAIL %s tick: got %b expected %b at %0t", name, tick, expTick, $time);
    end
    checks++;
    if (divErr !== expErr) begin
      errors++;
      $display("[TB] FAIL %s div_err: got %b expected %b at %0t", name, divErr, expErr, $time);
    end
  endtask

  task automatic idleStep(input string name, input logic [1:0] e);
    applyStimulus(1'b0, e, 1'b0, 1'b0, 3'd0, 25'd0);
    checkOutput(name, mclk, mtick, merr);
  endtask

  // Runs enabled cycles until channel ch ticks; a missing tick within the bound counts as a failure
  task automatic waitTick(input int ch, input int expected, input string name);
    int n;
    bit seen;
    n = -1;
    seen = 0;
    for (int i = 1; i <= expected + 8 && !seen; i++) begin
      idleStep(name, 2'b11);
      if (tick[ch] === 1'b1) begin
        seen = 1;
        n = i;
      end
    end
    checks++;
    if (!seen || n != expected) begin
      errors++;
      $display("[TB] FAIL %s period: got %0d cycles expected %0d", name, n, expected);
    end
  endtask

  initial begin
    int first0, first1;

    // Reset defaults: 3 reset cycles, then channel 0 must tick after exactly 25000 cycles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 3'd0, 25'd0);
      checkOutput("resetHold", 2'b00, 2'b00, 1'b0);
    end
    waitTick(0, INIT0, "defaultCh0");
    for (int i = 0; i < 5; i++) idleStep("defaultAfterTick", 2'b11);

    tbl.push_back(mk(1, 2'b00, 0, 0, 3'd0, 25'd0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(1, 2'b11, 1, 1, 3'd0, 25'd9, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 2'b00, 1, 1, 3'd0, 25'd5, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 2'b00, 1, 1, 3'd1, 25'd0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 3'd0, 25'd0, 2'b10, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 3'd0, 25'd0, 2'b00, 2'b10, 0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 3'd0, 25'd0, 2'b11, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 3'd0, 25'd0, 2'b01, 2'b10, 0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 3'd0, 25'd0, 2'b10, 2'b01, 0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 3'd0, 25'd0, 2'b00, 2'b10, 0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 3'd0, 25'd0, 2'b10, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 0, 1, 3'd5, 25'd7, 2'b01, 2'b10, 1));
    tbl.push_back(mk(0, 2'b11, 0, 1, 3'd2, 25'd3, 2'b11, 2'b00, 1));
    tbl.push_back(mk(0, 2'b11, 0, 0, 3'd0, 25'd0, 2'b00, 2'b11, 0));
    tbl.push_back(mk(0, 2'b01, 0, 0, 3'd0, 25'd0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 2'b01, 0, 0, 3'd0, 25'd0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 2'b01, 0, 0, 3'd0, 25'd0, 2'b01, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 3'd0, 25'd0, 2'b11, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 1, 0, 3'd0, 25'd0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 3'd0, 25'd0, 2'b10, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 3'd0, 25'd0, 2'b00, 2'b10, 0));

    foreach (tbl[k]) begin
      applyStimulus(tbl[k].r, tbl[k].en, tbl[k].s, tbl[k].w, tbl[k].ch, tbl[k].d);
      checkOutput($sformatf("table[%0d]", k), tbl[k].eClk, tbl[k].eTick, tbl[k].eErr);
    end

`ifndef CLKDIV_DEFERRED_LOAD_EN
    // Immediate write mid-period restarts channel 0 on the write edge
    idleStep("preWrite", 2'b11);
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b1, 3'd0, 25'd5);
    checkOutput("writeEdge", mclk, mtick, merr);
    checks++;
    if (clkOut[0] !== 1'b0 || tick[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL writeEdgeCh0: got clk %b tick %b expected 0 0", clkOut[0], tick[0]);
    end
    waitTick(0, 5, "oddDivCh0");
    waitTick(0, 5, "oddDivCh0Again");
`else
    // Deferred write at cnt=3 must not truncate the running 10-cycle period
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b1, 3'd0, 25'd10);
    checkOutput("defSetup", mclk, mtick, merr);
    for (int i = 0; i < 3; i++) idleStep("defRun", 2'b11);
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b1, 3'd0, 25'd4);
    checkOutput("defWrite", mclk, mtick, merr);
    waitTick(0, 6, "defOldPeriod");
    waitTick(0, 4, "defNewPeriod");
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b1, 3'd0, 25'd7);
    checkOutput("defWrite2", mclk, mtick, merr);
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 3'd0, 25'd0);
    checkOutput("defSync", mclk, mtick, merr);
    waitTick(0, 7, "defSyncApplied");
`endif

    // Enable hold and sync restart with div0=10, div1=4
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b1, 3'd0, 25'd10);
    checkOutput("enSetup0", mclk, mtick, merr);
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b1, 3'd1, 25'd4);
    checkOutput("enSetup1", mclk, mtick, merr);
    for (int i = 0; i < 5; i++) idleStep("enRun", 2'b11);
    for (int i = 0; i < 7; i++) begin
      idleStep("enHold", 2'b10);
      checks++;
      if (clkOut[0] !== 1'b1 || tick[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL enHoldCh0: got clk %b tick %b expected 1 0", clkOut[0], tick[0]);
      end
    end
    idleStep("enResume", 2'b11);
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 3'd0, 25'd0);
    checkOutput("syncPulse", 2'b00, 2'b00, 1'b0);
    first0 = -1;
    first1 = -1;
    for (int i = 1; i <= 12; i++) begin
      idleStep("afterSync", 2'b11);
      if (tick[0] === 1'b1 && first0 < 0) first0 = i;
      if (tick[1] === 1'b1 && first1 < 0) first1 = i;
    end
    checks++;
    if (first0 != 10 || first1 != 4) begin
      errors++;
      $display("[TB] FAIL firstTicks: got %0d/%0d expected 10/4", first0, first1);
    end

    // Reset at cnt=7 with a write outstanding; divisors must return to their reset values
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 3'd0, 25'd0);
    checkOutput("rstSetup", mclk, mtick, merr);
    for (int i = 0; i < 7; i++) idleStep("rstRun", 2'b11);
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b1, 3'd0, 25'd3);
    checkOutput("rstPendWrite", mclk, mtick, merr);
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b1, 3'd1, 25'd3);
    checkOutput("midReset", 2'b00, 2'b00, 1'b0);
    waitTick(0, INIT0, "postResetCh0");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, w;
      logic [1:0]  e;
      logic [2:0]  c;
      logic [24:0] d;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 31) == 0);
      w = ($urandom_range(0, 11) == 0);
      e[0] = ($urandom_range(0, 5) != 0);
      e[1] = ($urandom_range(0, 5) != 0);
      c = 3'($urandom_range(0, 7) < 6 ? $urandom_range(0, 1) : $urandom_range(2, 7));
      d = 25'($urandom_range(0, 12));
      applyStimulus(r, e, s, w, c, d);
      checkOutput("random", mclk, mtick, merr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
